residual_layernorm: RTL and testbench

RESIDUAL_LAYERNORM -- requirements
Module: residual_layernorm

---
 rtl/residual_layernorm_pkg.sv | 25 ++
 rtl/residual_layernorm_rsqrt_seq.sv | 85 ++++++++
 rtl/residual_layernorm.sv | 133 +++++++++++++
 tb/tb_residual_layernorm.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/residual_layernorm_pkg.sv
// Shared fixed-point definitions for the transformer datapath blocks (FFN, attention, layernorm).
package residual_layernorm_pkg;

    localparam int FRAC_BITS   = 8;
    localparam int ONE         = 256;
    localparam int EPS_DEFAULT = 1;

    typedef enum logic [2:0] {
        IDLE, SUM, MEAN, VAR, SQRT, RECIP, NORM, DONE
    } ln_state_t;

    typedef enum logic [1:0] {
        R_IDLE, R_SQRT, R_DIV
    } rs_phase_t;

    function automatic logic signed [15:0] sat16(input logic signed [47:0] v);
        if (v > 48'sd32767)
            return 16'sh7fff;
        else if (v < -48'sd32768)
            return 16'sh8000;
        else
            return v[15:0];
    endfunction

endpackage

// File: rtl/residual_layernorm_rsqrt_seq.sv
// Sequential 1/sqrt: 16-step restoring square root of vpe<<8, then 17-step restoring 65536/std.
module rsqrt_seq
    import residual_layernorm_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] vpe,
    output logic        done,
    output logic [15:0] inv
);

    localparam logic [16:0] DIVIDEND = 17'(ONE * ONE);

    rs_phase_t   phase;
    logic [4:0]  cnt;
    logic [31:0] rad, rad_src;
    logic [17:0] rem, rem_src;
    logic [19:0] rem_sh, trial;
    logic [15:0] root, root_src;
    logic [15:0] drem, drem_nx;
    logic [16:0] drem_sh;
    logic        s_bit, q_bit;

    // The first root bit is resolved on the start edge itself so both phases fit in 33 cycles.
    always_comb begin
        rad_src  = start ? {8'd0, vpe, 8'd0} : rad;
        rem_src  = start ? '0 : rem;
        root_src = start ? '0 : root;
        rem_sh   = {rem_src, rad_src[31:30]};
        trial    = {2'b00, root_src, 2'b01};
        s_bit    = (rem_sh >= trial);
        drem_sh  = {drem, DIVIDEND[5'd16 - cnt]};
        q_bit    = (drem_sh >= {1'b0, root});
        drem_nx  = q_bit ? 16'(drem_sh - {1'b0, root}) : drem_sh[15:0];
        done     = (phase == R_DIV) && (cnt == 5'd16);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            phase <= R_IDLE;
            cnt   <= '0;
            rad   <= '0;
            rem   <= '0;
            root  <= '0;
            drem  <= '0;
            inv   <= '0;
        end else begin
            case (phase)
                R_IDLE: if (start) begin
                    rad   <= {rad_src[29:0], 2'b00};
                    rem   <= s_bit ? 18'(rem_sh - trial) : rem_sh[17:0];
                    root  <= {root_src[14:0], s_bit};
                    drem  <= '0;
                    inv   <= '0;
                    cnt   <= 5'd1;
                    phase <= R_SQRT;
                end
                R_SQRT: begin
                    rad  <= {rad_src[29:0], 2'b00};
                    rem  <= s_bit ? 18'(rem_sh - trial) : rem_sh[17:0];
                    root <= {root_src[14:0], s_bit};
                    if (cnt == 5'd15) begin
                        cnt   <= '0;
                        phase <= R_DIV;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                R_DIV: begin
                    drem <= drem_nx;
                    inv  <= {inv[14:0], q_bit};
                    if (cnt == 5'd16) begin
                        cnt   <= '0;
                        phase <= R_IDLE;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                default: phase <= R_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/residual_layernorm.sv
// Residual add followed by LayerNorm over one EMBED_DIM vector, one element per cycle, Q8.8.
module residual_layernorm
    import residual_layernorm_pkg::*;
#(
    parameter int EMBED_DIM  = 4,
    parameter int DATA_WIDTH = 16,
    parameter int EPS        = EPS_DEFAULT
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            valid_in,
    output logic                            in_ready,
    input  logic [EMBED_DIM*DATA_WIDTH-1:0] x_res,
    input  logic [EMBED_DIM*DATA_WIDTH-1:0] y_ffn,
    input  logic [EMBED_DIM*DATA_WIDTH-1:0] gamma_flat,
    input  logic [EMBED_DIM*DATA_WIDTH-1:0] beta_flat,
    output logic [EMBED_DIM*DATA_WIDTH-1:0] z_out,
    output logic                            valid_out
);

    localparam int LOG2  = $clog2(EMBED_DIM);
    localparam int VW    = DATA_WIDTH + 1;
    localparam int SUM_W = DATA_WIDTH + LOG2;
    localparam int ACC_W = 2 * VW + LOG2;
    localparam int CNT_W = LOG2 + 5;

    ln_state_t state, next_state;
    logic [CNT_W-1:0] cnt;
    logic [LOG2-1:0]  idx;

    logic signed [DATA_WIDTH-1:0] xa [EMBED_DIM];
    logic signed [DATA_WIDTH-1:0] ya [EMBED_DIM];
    logic signed [DATA_WIDTH-1:0] ga [EMBED_DIM];
    logic signed [DATA_WIDTH-1:0] ba [EMBED_DIM];
    logic signed [DATA_WIDTH-1:0] h  [EMBED_DIM];
    logic signed [VW-1:0]         d  [EMBED_DIM];
    logic signed [DATA_WIDTH-1:0] zw [EMBED_DIM];

    logic signed [SUM_W-1:0]      sum;
    logic signed [DATA_WIDTH-1:0] mean;
    logic signed [ACC_W-1:0]      acc, var_w, vpe_w;
    logic signed [DATA_WIDTH-1:0] h_new, n_e, z_e;
    logic signed [VW-1:0]         d_new;
    logic signed [2*VW-1:0]       d_sq;
    logic signed [47:0]           t_n, t_z;
    logic [15:0]                  vpe, inv;
    logic                         rs_start, rs_done;

    assign idx      = cnt[LOG2-1:0];
    assign in_ready = (state == IDLE);

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (valid_in) next_state = SUM;
            SUM:     if (cnt == CNT_W'(EMBED_DIM - 1)) next_state = MEAN;
            MEAN:    next_state = VAR;
            VAR:     if (cnt == CNT_W'(EMBED_DIM - 1)) next_state = SQRT;
            SQRT:    if (cnt == CNT_W'(15)) next_state = RECIP;
            RECIP:   if (rs_done) next_state = NORM;
            NORM:    if (cnt == CNT_W'(EMBED_DIM - 1)) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
        rs_start = (state == SQRT) && (cnt == '0);
    end

    always_comb begin
        h_new = DATA_WIDTH'(sat16(48'(xa[idx]) + 48'(ya[idx])));
        d_new = VW'(h[idx]) - VW'(mean);
        d_sq  = d_new * d_new;
        var_w = acc >>> (FRAC_BITS + LOG2);
        vpe_w = var_w + ACC_W'(EPS);
        vpe   = (vpe_w > ACC_W'(32767)) ? 16'h7fff : 16'(vpe_w);
        t_n   = (48'(d[idx]) * 48'(signed'({1'b0, inv}))) >>> FRAC_BITS;
        n_e   = DATA_WIDTH'(sat16(t_n));
        t_z   = ((48'(n_e) * 48'(ga[idx])) >>> FRAC_BITS) + 48'(ba[idx]);
        z_e   = DATA_WIDTH'(sat16(t_z));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            sum       <= '0;
            mean      <= '0;
            acc       <= '0;
            valid_out <= 1'b0;
            z_out     <= '0;
        end else begin
            state     <= next_state;
            cnt       <= (state != next_state) ? '0 : cnt + CNT_W'(1);
            valid_out <= (state == DONE);
            case (state)
                IDLE: if (valid_in) begin
                    sum <= '0;
                    acc <= '0;
                end
                SUM:  sum  <= sum + SUM_W'(h_new);
                MEAN: mean <= DATA_WIDTH'(sum >>> LOG2);
                VAR:  acc  <= acc + ACC_W'(d_sq);
                DONE: for (int unsigned i = 0; i < EMBED_DIM; i++)
                    z_out[i*DATA_WIDTH +: DATA_WIDTH] <= zw[i];
                default: ;
            endcase
        end
    end

    // Operand and per-element scratch storage needs no reset; it is always written before use.
    always_ff @(posedge clk) begin
        if (state == IDLE && valid_in) begin
            for (int unsigned i = 0; i < EMBED_DIM; i++) begin
                xa[i] <= x_res[i*DATA_WIDTH +: DATA_WIDTH];
                ya[i] <= y_ffn[i*DATA_WIDTH +: DATA_WIDTH];
                ga[i] <= gamma_flat[i*DATA_WIDTH +: DATA_WIDTH];
                ba[i] <= beta_flat[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        if (state == SUM)  h[idx]  <= h_new;
        if (state == VAR)  d[idx]  <= d_new;
        if (state == NORM) zw[idx] <= z_e;
    end

    rsqrt_seq u_rsqrt (
        .clk   (clk),
        .rst   (rst),
        .start (rs_start),
        .vpe   (vpe),
        .done  (rs_done),
        .inv   (inv)
    );

endmodule

// File: tb/tb_residual_layernorm.sv
// Directed-vector scoreboard bench for residual_layernorm (EMBED_DIM=4, Q8.8).
module tb_residual_layernorm;

    localparam int E  = 4;
    localparam int W  = 16;
    localparam int FW = E * W;
    localparam int LAT = 3 * E + 35;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          valid_in = 1'b0;
    logic          in_ready, valid_out;
    logic [FW-1:0] x_res = '0, y_ffn = '0, gamma_flat = '0, beta_flat = '0;
    logic [FW-1:0] z_out;

    residual_layernorm #(.EMBED_DIM(E), .DATA_WIDTH(W), .EPS(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (valid_in),
        .in_ready   (in_ready),
        .x_res      (x_res),
        .y_ffn      (y_ffn),
        .gamma_flat (gamma_flat),
        .beta_flat  (beta_flat),
        .z_out      (z_out),
        .valid_out  (valid_out)
    );

    typedef struct {
        int          id;
        int          stamp;
        logic [FW-1:0] zf;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0, checks = 0, errors = 0, pulses = 0, busy_until = 0;
    bit   mon_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [FW-1:0] v4(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // in_ready model plus output scoreboard, sampled on the falling edge
    always @(negedge clk) begin : monitor
        exp_t e;
        logic signed [W-1:0] a, x;
        if (mon_en) begin
            checks++;
            if (in_ready !== (cyc >= busy_until)) begin
                errors++;
                $display("FAIL in_ready: got %b expected %b (cycle %0d)", in_ready, cyc >= busy_until, cyc);
            end
            if (valid_out === 1'b1) begin
                pulses++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid_out: got 1 expected 0 (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    if (cyc - e.stamp != LAT) begin
                        errors++;
                        $display("FAIL latency_t%0d: got %0d expected %0d", e.id, cyc - e.stamp, LAT);
                    end
                    for (int i = 0; i < E; i++) begin
                        a = z_out[i*W +: W];
                        x = e.zf[i*W +: W];
                        checks++;
                        if (a !== x) begin
                            errors++;
                            $display("FAIL z_t%0d[%0d]: got %0d expected %0d", e.id, i, a, x);
                        end
                    end
                end
            end
        end
    end

    task automatic send(input int id, input logic [FW-1:0] x, input logic [FW-1:0] y,
                        input logic [FW-1:0] g, input logic [FW-1:0] b,
                        input logic [FW-1:0] zexp, input bit hold, output int stamp);
        exp_t e;
        bit   got = 1'b0;
        x_res = x; y_ffn = y; gamma_flat = g; beta_flat = b;
        valid_in = 1'b1;
        stamp = -1;
        for (int n = 0; n < 200 && !got; n++) begin
            @(posedge clk);
            if (in_ready === 1'b1) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL transfer_t%0d: got no transfer expected one within 200 cycles", id);
            valid_in = 1'b0;
            return;
        end
        #1;
        stamp = cyc;
        e.id = id; e.stamp = cyc; e.zf = zexp;
        sb.push_back(e);
        busy_until = cyc + LAT;
        // Scramble operands right after the transfer; only latched values may matter.
        x_res = {$urandom(), $urandom()};
        y_ffn = {$urandom(), $urandom()};
        gamma_flat = {$urandom(), $urandom()};
        beta_flat = {$urandom(), $urandom()};
        if (!hold) valid_in = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    logic [FW-1:0] G1, Y1, Z1;
    int s1, s2, p0;

    initial begin
        G1 = v4(256, 256, 256, 256);
        Y1 = v4(256, 512, 768, 1024);
        Z1 = v4(-344, -115, 114, 343);

        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_valid_out", valid_out, 0);
        chk("reset_z_out", z_out, 0);
        @(negedge clk);
        rst = 1'b1;
        busy_until = cyc;
        mon_en = 1'b1;

        send(1, '0, Y1, G1, '0, Z1, 1'b0, s1);
        send(2, '0, v4(500, 500, 500, 500), G1, v4(10, 20, 30, 40), v4(10, 20, 30, 40), 1'b0, s1);
        send(3, v4(32767, 0, 0, 0), v4(256, 0, 0, 0), G1, '0, v4(2112, -704, -704, -704), 1'b0, s1);
        send(4, v4(100, -100, 300, -300), '0, v4(512, 256, 128, -256), v4(0, 256, -256, 0),
             v4(228, 141, -85, 343), 1'b0, s1);
        drain();

        send(5, '0, Y1, G1, '0, Z1, 1'b1, s1);
        send(6, '0, v4(500, 500, 500, 500), G1, v4(10, 20, 30, 40), v4(10, 20, 30, 40), 1'b0, s2);
        chk("b2b_period", s2 - s1, LAT + 1);
        drain();

        p0 = pulses;
        send(7, '0, Y1, G1, '0, Z1, 1'b0, s1);
        while (cyc < s1 + 19) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        sb.delete();
        busy_until = cyc;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_valid_out", valid_out, 0);
        chk("abort_z_out", z_out, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (60) @(negedge clk);
        chk("abort_no_pulse", pulses, p0);

        send(8, '0, Y1, G1, '0, Z1, 1'b0, s1);
        drain();
        chk("pulse_count", pulses, 7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
